// File: rtl/alu_issue_stage.sv
// Operand-issue and writeback stage feeding an external combinational 32-bit ALU.
// Owns the 8x32 register file, the carry flag and the retired-instruction counter.
//
// state | meaning
// IDLE  | ready for an instruction; operands are read and latched on accept
// EXEC  | ALU operands held stable; result retired on the first cycle without stall
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 8,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  input  logic              instr_imm_en,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic              stall,
  output logic [DATA_W-1:0] ALU_a,
  output logic [DATA_W-1:0] ALU_b,
  output logic [2:0]        CTRL,
  input  logic [DATA_W-1:0] ALU_c,
  input  logic              Cout,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              carry_flag,
  output logic [CNT_W-1:0]  retire_cnt,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b111;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               retire;
  logic [REG_AW-1:0]  rd_q;
  logic [DATA_W-1:0]  regs [REG_N];
  logic [DATA_W-1:0]  rs1_val;
  logic [DATA_W-1:0]  rs2_val;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (instr_valid) state_nxt = EXEC;
      EXEC:    if (!stall)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    accept      = 1'b0;
    retire      = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        accept      = instr_valid;
      end
      EXEC:    retire = !stall;
      default: ;
    endcase
  end

  // ---------------- operand read ----------------
  // r0 is hard-wired to zero on every read port.
  always_comb begin
    rs1_val = (instr_rs1 == '0) ? '0 : regs[instr_rs1];
    rs2_val = (instr_rs2 == '0) ? '0 : regs[instr_rs2];
    dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
  end

  always_comb begin
    op_a = rs1_val;
    op_b = instr_imm_en ? instr_imm : rs2_val;
    if (instr_op == OP_MOV) begin
      op_a = instr_imm_en ? instr_imm : rs1_val;
      op_b = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_a <= '0;
      ALU_b <= '0;
      CTRL  <= OP_MOV;
      rd_q  <= '0;
    end else if (accept) begin
      ALU_a <= op_a;
      ALU_b <= op_b;
      CTRL  <= instr_op;
      rd_q  <= instr_rd;
    end
  end

  // ---------------- writeback ----------------
  // Register write lands on the retire edge, so the very next accept already sees it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (retire && (rd_q != '0)) begin
      regs[rd_q] <= ALU_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= retire;
      if (retire) begin
        wb_rd   <= rd_q;
        wb_data <= ALU_c;
      end
    end
  end

  // Cout is floating for non-arithmetic ops, so it is only sampled for ADD/SUB.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_flag <= 1'b0;
    end else if (retire && ((CTRL == OP_ADD) || (CTRL == OP_SUB))) begin
      carry_flag <= Cout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         retire_cnt <= '0;
    else if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
  end

endmodule
